seven_seg_scanner: RTL
======================

# seven_seg_scanner

Time-multiplexed controller for the board's 4-digit common-anode seven-segment display. It owns the `segment` and `anode` pins and scans four hex digits in turn. Each digit slot opens with an all-off guard interval to suppress ghosting. A load/commit scheme double-buffers the digit data, so the display only changes on frame boundaries. Top-level designs instantiate it in place of hard-wiring a single anode.

## Interface
- `DIGIT_CYCLES`, default 100000: clocks per digit slot, including the guard interval; legal range is greater than GUARD_CYCLES and at most 2^20.
- `GUARD_CYCLES`, default 1000: clocks at the start of each slot with all anodes off; legal range is at least 1.
- `clk`  in  1  system clock; the block uses one clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `data_in`  in  16  four hex digits; digit k is `data_in[4k+3:4k]`; digit 0 is the rightmost, on anode[0].
- `dp_in`  in  4  decimal-point enable per digit, active-high.
- `blank_in`  in  4  blank mask per digit, active-high; a blanked digit keeps its anode off for the whole slot.
- `load`  in  1  single-cycle strobe; captures data_in, dp_in and blank_in into the pending buffer.
- `pending`  out  1  high while the pending buffer holds data that has not yet been committed.
- `frame_done`  out  1  one-cycle pulse on the last clock of the digit-3 slot.
- `segment`  out  8  active-low; bits [6:0] = {g,f,e,d,c,b,a}; bit 7 = DP.
- `anode`  out  4  active-low digit enables.

## Operation
- Slot counter `cnt`, 20 bits, runs 0..DIGIT_CYCLES-1 and then wraps to 0.
  - On wrap, the digit index `dig` (2 bits) increments and wraps from 3 to 0.
- Per-slot FSM, states GUARD and DRIVE:
  - GUARD holds while cnt < GUARD_CYCLES. Outputs are anode=4'b1111 and segment=8'hFF.
  - DRIVE holds while cnt ≥ GUARD_CYCLES.
    - If the active blank bit for `dig` is 0: anode = ~(4'b0001 << dig), segment[6:0] = hex decode of the active nibble, segment[7] = ~active_dp[dig].
    - If the active blank bit for `dig` is 1: outputs stay as in GUARD.
  - A transition to GUARD occurs on every slot wrap.
- Hex decode is standard, with 0..F mapping to 0-9,A,b,C,d,E,F. Active-low patterns:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E
- Buffering:
  - A `load` writes the pending regs and sets `pending`.
  - On a `frame_done` cycle with `pending`=1, the active regs take the pending values and `pending` clears.
  - Multiple loads inside one frame: the last one wins.
- Simultaneous `load` and commit on the same cycle: the commit uses the pending contents from before this cycle. The new load is written to pending and `pending` stays 1, so it commits at the next frame boundary.
- Outputs are registered. `segment` and `anode` come from flops and are never glitched by the decode logic.

## Timing
- Reset state:
  - cnt=0, dig=0, FSM=GUARD.
  - anode=4'b1111, segment=8'hFF.
  - pending=0, frame_done=0.
  - Active and pending data=16'h0000, dp=4'h0, blank=4'h0.
  - After reset the display therefore shows "0000".
- Reset asserted mid-frame forces outputs to the reset values in the same cycle, asynchronously. A pending load is discarded.
- Output latency is one clock from the counter/state update. The first DRIVE output appears on the clock at which cnt = GUARD_CYCLES.
- The commit takes effect on the outputs from the digit-0 slot that follows the `frame_done` cycle. Digit 0 of that slot is driven in DRIVE after the guard interval.
- The frame period is exactly 4×DIGIT_CYCLES clocks. `frame_done` is high on cycles where dig=3 and cnt=DIGIT_CYCLES-1.
- `pending` rises one clock after `load` and falls one clock after the committing `frame_done`.

## Test plan
Use DIGIT_CYCLES=8 and GUARD_CYCLES=2 throughout.
- **Reset.** Release reset.
  - Anode sequence per slot is 1111,1111, then 1110 ×6; next slot 1111,1111, then 1101 ×6; and so on.
  - segment=8'hC0 during DRIVE.
  - frame_done pulses every 32 clocks.
- **Load.** Load data_in=16'hA5F3, dp_in=4'b0100 mid-frame.
  - pending=1 until frame_done.
  - The next frame shows segment 8'hB0 (3), 8'h8E (F), 8'h12 (5, DP on), 8'h88 (A) on digits 0..3.
- **Blank mask.** Load blank_in=4'b1010.
  - After commit, anodes 1101 and 0111 are never asserted; slots 1 and 3 are all 1111 / 8'hFF.
- **Two loads in one frame.** Load 16'h1111 then 16'h2222 within one frame.
  - Only "2222" is ever displayed; "1111" never appears.
- **Load on the commit cycle.** Pending holds 16'h1234; load 16'h5678 on the frame_done cycle.
  - The next frame shows 1234 and pending stays 1.
  - The following frame shows 5678 and pending clears.
- **Reset mid-frame.** Assert reset during the dig=2 DRIVE state with pending=1.
  - Outputs go to 1111 / 8'hFF immediately; pending=0.
  - After release, the display shows "0000" starting at the dig=0 GUARD state.

Source files
------------

// File: rtl/seven_seg_scanner_if.sv
// Bus between a display owner (master) and the seven-segment scanner (slave):
// digit data/controls in, registered pin drives and buffer status out.
interface seven_seg_scanner_if;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        load;
    logic        pending;
    logic        frame_done;
    logic [7:0]  segment;
    logic [3:0]  anode;

    modport master (
        output data_in,
        output dp_in,
        output blank_in,
        output load,
        input  pending,
        input  frame_done,
        input  segment,
        input  anode
    );

    modport slave (
        input  data_in,
        input  dp_in,
        input  blank_in,
        input  load,
        output pending,
        output frame_done,
        output segment,
        output anode
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode seven-segment scanner with per-slot ghosting guard
// and a load/commit double buffer that only swaps on frame boundaries.
module seven_seg_scanner #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int GUARD_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               reset,
    seven_seg_scanner_if.slave bus
);

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam logic [19:0] CNT_LAST  = 20'(DIGIT_CYCLES - 1);
    localparam logic [19:0] GUARD_CNT = 20'(GUARD_CYCLES);

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            default: pat = 7'h0E;
        endcase
        return pat;
    endfunction

    logic [19:0] cnt;
    logic [19:0] cnt_nxt;
    logic [1:0]  dig;
    logic [1:0]  dig_nxt;
    logic        wrap;
    state_t      state;
    state_t      state_nxt;

    logic [15:0] act_data;
    logic [3:0]  act_dp;
    logic [3:0]  act_blank;
    logic [15:0] pend_data;
    logic [3:0]  pend_dp;
    logic [3:0]  pend_blank;
    logic        pend_vld;
    logic        frame_done_q;
    logic        commit;

    logic [3:0]  anode_p0;
    logic [7:0]  seg_p0;
    logic [3:0]  anode_p1;
    logic [7:0]  seg_p1;

    // Slot counter and digit index
    assign wrap = (cnt == CNT_LAST);

    always_comb begin
        cnt_nxt = wrap ? 20'd0 : cnt + 20'd1;
        dig_nxt = wrap ? dig + 2'd1 : dig;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= 20'd0;
            dig          <= 2'd0;
            frame_done_q <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            dig          <= dig_nxt;
            frame_done_q <= (dig_nxt == 2'd3) && (cnt_nxt == CNT_LAST);
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= GUARD;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: every wrap reopens the slot with a guard interval
    always_comb begin
        state_nxt = state;
        case (state)
            GUARD: if (!wrap && (cnt_nxt >= GUARD_CNT)) state_nxt = DRIVE;
            DRIVE: if (wrap) state_nxt = GUARD;
            default: state_nxt = GUARD;
        endcase
    end

    // FSM outputs, decoded from the active buffer
    always_comb begin
        anode_p0 = 4'b1111;
        seg_p0   = 8'hFF;
        if ((state == DRIVE) && !act_blank[dig]) begin
            anode_p0 = ~(4'b0001 << dig);
            seg_p0   = {~act_dp[dig], hex7(act_data[{dig, 2'b00} +: 4])};
        end
    end

    // Output registers keep the pins free of decode glitches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode_p1 <= 4'b1111;
            seg_p1   <= 8'hFF;
        end else begin
            anode_p1 <= anode_p0;
            seg_p1   <= seg_p0;
        end
    end

    // Double buffer: a commit reads the pending contents from before this
    // edge, so a load on the commit cycle waits for the next frame boundary.
    assign commit = frame_done_q && pend_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_data   <= 16'h0000;
            act_dp     <= 4'h0;
            act_blank  <= 4'h0;
            pend_data  <= 16'h0000;
            pend_dp    <= 4'h0;
            pend_blank <= 4'h0;
            pend_vld   <= 1'b0;
        end else begin
            if (commit) begin
                act_data  <= pend_data;
                act_dp    <= pend_dp;
                act_blank <= pend_blank;
            end
            if (bus.load) begin
                pend_data  <= bus.data_in;
                pend_dp    <= bus.dp_in;
                pend_blank <= bus.blank_in;
                pend_vld   <= 1'b1;
            end else if (commit) begin
                pend_vld <= 1'b0;
            end
        end
    end

    assign bus.anode      = anode_p1;
    assign bus.segment    = seg_p1;
    assign bus.pending    = pend_vld;
    assign bus.frame_done = frame_done_q;

endmodule
